// File: rtl/move_tick_gen_pkg.sv
// move_tick_gen_pkg: shared game-flow state encodings and widths for the snake move pacer.
package move_tick_gen_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_OVER  = 2'd3
  } state_e;
  localparam int DIV_W_DEF = 32;
  localparam int LVL_W     = 2;
  localparam int CNT_W     = 16;
endpackage

// File: rtl/tap_edge_det.sv
// tap_edge_det: registers the selected divider tap and flags its rising edge.
module tap_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);
  logic d_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) d_q <= 1'b0;
    else        d_q <= d;
  assign rise = d & ~d_q;
endmodule

// File: rtl/move_tick_gen.sv
// move_tick_gen: speed-selected clkdiv tap -> one-cycle move_tick, plus IDLE/RUN/PAUSE/OVER game flow.
// Optional SPEED_RAMP_EN adds automatic speed stepping every RAMP_TICKS move ticks.
module move_tick_gen
  import move_tick_gen_pkg::*;
#(
  parameter int DIV_W      = DIV_W_DEF,
  parameter int TAP_BASE   = 24,
  parameter int MAX_LEVEL  = 3,
  parameter int RAMP_TICKS = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] clkdiv,
  input  logic             start,
  input  logic             pause,
  input  logic             speed_up,
  input  logic             speed_down,
  input  logic             game_over,
  output logic             move_tick,
  output logic             running,
  output logic [LVL_W-1:0] speed_level,
  output logic [CNT_W-1:0] tick_count
);
  state_e           state_q, state_d;
  logic [LVL_W-1:0] speed_level_q, speed_level_d, lvl_inc, lvl_dec;
  logic [CNT_W-1:0] tick_count_q, tick_count_d;
  logic             move_tick_q, move_tick_d, running_q;
  logic [MAX_LEVEL:0] taps;
  logic             tap, rise, ramp_step, unused_div;
  // taps[0] is the fastest bit; level L reads taps[MAX_LEVEL-L]
  assign taps = clkdiv[TAP_BASE-MAX_LEVEL +: MAX_LEVEL+1];
  assign tap  = taps[LVL_W'(MAX_LEVEL) - speed_level_q];
  assign unused_div = ^{clkdiv[DIV_W-1:TAP_BASE+1], clkdiv[TAP_BASE-MAX_LEVEL-1:0]};
  tap_edge_det u_edge (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (tap),
    .rise (rise)
  );
  always_comb begin
    state_d = start ? ST_RUN :
              (state_q == ST_RUN)   ? (game_over ? ST_OVER : pause ? ST_PAUSE : ST_RUN) :
              (state_q == ST_PAUSE && pause) ? ST_RUN : state_q;
    move_tick_d   = (state_q == ST_RUN) & (state_d == ST_RUN) & rise;
    tick_count_d  = start ? '0 : tick_count_q + CNT_W'(move_tick_d);
    lvl_inc       = (speed_level_q == LVL_W'(MAX_LEVEL)) ? speed_level_q : speed_level_q + 1'b1;
    lvl_dec       = (speed_level_q == '0) ? speed_level_q : speed_level_q - 1'b1;
    speed_level_d = (speed_up & ~speed_down) ? lvl_inc :
                    (speed_down & ~speed_up) ? lvl_dec :
                    (ramp_step & ~speed_up & ~speed_down) ? lvl_inc : speed_level_q;
  end
`ifdef SPEED_RAMP_EN
  localparam int RW = $clog2(RAMP_TICKS + 1);
  logic [RW-1:0] ramp_q, ramp_d;
  assign ramp_step = ~start & move_tick_d & (ramp_q == RW'(RAMP_TICKS - 1));
  assign ramp_d    = (start | ramp_step) ? '0 : ramp_q + RW'(move_tick_d);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ramp_q <= '0;
    else        ramp_q <= ramp_d;
`else
  logic unused_ramp;
  assign ramp_step   = 1'b0;
  assign unused_ramp = RAMP_TICKS[0];
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      speed_level_q <= '0;
      tick_count_q  <= '0;
      move_tick_q   <= 1'b0;
      running_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      speed_level_q <= speed_level_d;
      tick_count_q  <= tick_count_d;
      move_tick_q   <= move_tick_d;
      running_q     <= (state_d == ST_RUN);
    end
  assign move_tick   = move_tick_q;
  assign running     = running_q;
  assign speed_level = speed_level_q;
  assign tick_count  = tick_count_q;
endmodule
